// File: rtl/ws2812b_pkg.sv
// ws2812b_pkg: shared defaults, colour byte offsets, FSM encoding and channel scaler
package ws2812b_pkg;
    localparam int DEF_NUM_LEDS = 64;
    localparam int DEF_FRAME_GAP_CYCLES = 90000;
    localparam int R_OFS = 16;
    localparam int G_OFS = 8;
    localparam int B_OFS = 0;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SCALE, S_PRESENT, S_GAP} state_t;
    function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
        return 8'((16'(c) * (16'(b) + 16'd1)) >> 8);
    endfunction
endpackage

// File: rtl/ws2812b_frame_ram.sv
// ws2812b_frame_ram: two pixel banks, synchronous write, registered read
module ws2812b_frame_ram
    import ws2812b_pkg::*;
#(
    parameter int NUM_LEDS = DEF_NUM_LEDS,
    parameter int AW = $clog2(NUM_LEDS)
)(
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic          i_wr_bank,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [23:0]   i_wr_data,
    input  logic          i_rd_en,
    input  logic          i_rd_bank,
    input  logic [AW-1:0] i_rd_addr,
    output logic [23:0]   o_rd_data
);
    logic [23:0] r_bank0 [NUM_LEDS];
    logic [23:0] r_bank1 [NUM_LEDS];
    logic [23:0] r_rd;

    always_ff @(posedge clk) begin
        if (i_wr_en && !i_wr_bank) r_bank0[i_wr_addr] <= i_wr_data;
        if (i_wr_en && i_wr_bank) r_bank1[i_wr_addr] <= i_wr_data;
        if (i_rd_en) r_rd <= i_rd_bank ? r_bank1[i_rd_addr] : r_bank0[i_rd_addr];
    end

    assign o_rd_data = r_rd;
endmodule

// File: rtl/ws2812b_pixel_feeder.sv
// ws2812b_pixel_feeder: double-buffered frame store feeding brightness-scaled GRB pixels to a serializer
module ws2812b_pixel_feeder
    import ws2812b_pkg::*;
#(
    parameter int NUM_LEDS = DEF_NUM_LEDS,
    parameter int FRAME_GAP_CYCLES = DEF_FRAME_GAP_CYCLES,
    localparam int AW = $clog2(NUM_LEDS)
)(
    input  logic          clk,
    input  logic          resetn,
    input  logic          enable,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [23:0]   wr_data,
    input  logic          swap_req,
    input  logic [7:0]    brightness,
    input  logic          bitstream_read,
    output logic          bitstream_available,
    output logic [23:0]   bitstream,
    output logic          swap_ack,
    output logic          frame_done
);
    localparam int GW = $clog2(FRAME_GAP_CYCLES + 1);
    localparam logic [AW-1:0] LAST = AW'(NUM_LEDS - 1);

    state_t r_state, w_next;
    logic [AW-1:0] r_idx;
    logic [GW-1:0] r_gap;
    logic [7:0] r_bright;
    logic [23:0] r_bits, w_rd_data;
    logic r_front, r_pend, r_swap_ack, r_done;
    logic w_consume, w_last, w_pend, w_swap, w_wr_ok, w_start;

    assign w_consume = r_state == S_PRESENT && bitstream_read;
    assign w_last = w_consume && r_idx == LAST;
    assign w_pend = r_pend | swap_req;
    assign w_swap = w_pend && (r_state == S_IDLE || (r_state == S_GAP && r_gap == '0));
    assign w_wr_ok = wr_en && 32'(wr_addr) < NUM_LEDS;
    assign w_start = r_state == S_IDLE && w_next == S_FETCH;

    ws2812b_frame_ram #(.NUM_LEDS(NUM_LEDS), .AW(AW)) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_ok),
        .i_wr_bank (~r_front),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_en   (r_state == S_FETCH),
        .i_rd_bank (r_front),
        .i_rd_addr (r_idx),
        .o_rd_data (w_rd_data)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (enable && r_gap == '0) w_next = S_FETCH;
            S_FETCH:   w_next = S_SCALE;
            S_SCALE:   w_next = S_PRESENT;
            S_PRESENT: if (bitstream_read) w_next = w_last ? S_GAP : S_FETCH;
            S_GAP:     if (r_gap == '0) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_idx <= '0;
            r_gap <= '0;
            r_bright <= '0;
            r_bits <= '0;
            r_front <= 1'b0;
            r_pend <= 1'b0;
            r_swap_ack <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_pend <= w_pend & ~w_swap;
            r_front <= r_front ^ w_swap;
            r_swap_ack <= w_swap;
            r_done <= w_last;
            if (w_start) r_bright <= brightness;
            if (w_start) r_idx <= '0;
            else if (w_consume) r_idx <= w_last ? '0 : r_idx + 1'b1;
            if (w_last) r_gap <= GW'(FRAME_GAP_CYCLES);
            else if (r_state == S_GAP && r_gap != '0) r_gap <= r_gap - 1'b1;
            if (r_state == S_SCALE)
                r_bits <= {scale_ch(w_rd_data[G_OFS +: 8], r_bright),
                           scale_ch(w_rd_data[R_OFS +: 8], r_bright),
                           scale_ch(w_rd_data[B_OFS +: 8], r_bright)};
        end
    end

    assign bitstream_available = r_state == S_PRESENT;
    assign bitstream = r_bits;
    assign swap_ack = r_swap_ack;
    assign frame_done = r_done;
endmodule

// File: tb/tb_ws2812b_pixel_feeder.sv
// tb_ws2812b_pixel_feeder: directed vector table plus hand-built frame, swap, gap and reset sequences
module tb_ws2812b_pixel_feeder;
    localparam int N = 4;
    localparam int GAP = 1000;

    logic clk = 0, resetn = 1, enable = 0, wr_en = 0, swap_req = 0, bitstream_read = 0;
    logic [1:0] wr_addr = 0;
    logic [23:0] wr_data = 0;
    logic [7:0] brightness = 0;
    logic bitstream_available, swap_ack, frame_done;
    logic [23:0] bitstream;
    logic enable2 = 0, wr_en2 = 0;
    logic [2:0] wr_addr2 = 0;
    logic bitstream_available2, swap_ack2, frame_done2;
    logic [23:0] bitstream2;

    int checks = 0, errors = 0;
    logic [23:0] m_bank [2][N];
    logic m_front;
    logic [23:0] fr_px [N];

    typedef struct { logic [23:0] rgb; logic [7:0] br; logic [23:0] exp; } vec_t;
    vec_t vecs [7];

    always #5 clk = ~clk;

    ws2812b_pixel_feeder #(.NUM_LEDS(N), .FRAME_GAP_CYCLES(GAP)) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .swap_req(swap_req), .brightness(brightness),
        .bitstream_read(bitstream_read), .bitstream_available(bitstream_available),
        .bitstream(bitstream), .swap_ack(swap_ack), .frame_done(frame_done)
    );

    ws2812b_pixel_feeder #(.NUM_LEDS(5), .FRAME_GAP_CYCLES(GAP)) dut5 (
        .clk(clk), .resetn(resetn), .enable(enable2), .wr_en(wr_en2), .wr_addr(wr_addr2),
        .wr_data(wr_data), .swap_req(swap_req), .brightness(brightness),
        .bitstream_read(bitstream_read), .bitstream_available(bitstream_available2),
        .bitstream(bitstream2), .swap_ack(swap_ack2), .frame_done(frame_done2)
    );

    function automatic logic [23:0] grb(input logic [23:0] c);
        return {c[15:8], c[23:16], c[7:0]};
    endfunction

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic write_px(input logic [1:0] a, input logic [23:0] d);
        @(negedge clk);
        wr_en = 1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 0;
        m_bank[!m_front][a] = d;
    endtask

    task automatic swap_idle();
        @(negedge clk);
        swap_req = 1;
        @(negedge clk);
        swap_req = 0;
        check("swap_ack_idle", 24'(swap_ack), 24'd1);
        m_front = !m_front;
    endtask

    task automatic get_px(output logic [23:0] px, output int lat, output bit ok);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bitstream_available && lat < 8);
        ok = bitstream_available;
        px = bitstream;
        repeat (2) begin
            @(negedge clk);
            check("hold_avail", 24'(bitstream_available), 24'd1);
            check("hold_data", bitstream, px);
        end
        bitstream_read = 1;
        @(negedge clk);
        bitstream_read = 0;
        check("read_drop", 24'(bitstream_available), 24'd0);
    endtask

    task automatic run_frame(input string name);
        int lat;
        bit ok;
        @(negedge clk);
        enable = 1;
        @(negedge clk);
        enable = 0;
        brightness = ~brightness;
        for (int i = 0; i < N; i++) begin
            get_px(fr_px[i], lat, ok);
            check({name, "_avail"}, 24'(ok), 24'd1);
            check({name, "_latency"}, 24'(lat <= 2), 24'd1);
            check({name, "_frame_done"}, 24'(frame_done), 24'(i == N - 1));
        end
        repeat (GAP + 5) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] got;
        int lat, gap_n, acks;
        bit ok;
        vecs[0] = '{24'h112233, 8'd255, 24'h221133};
        vecs[1] = '{24'hFF8002, 8'd127, 24'h407F01};
        vecs[2] = '{24'hFFFFFF, 8'd0,   24'h000000};
        vecs[3] = '{24'hFFFFFF, 8'd255, 24'hFFFFFF};
        vecs[4] = '{24'h80FF10, 8'd63,  24'h3F2004};
        vecs[5] = '{24'h0102FE, 8'd1,   24'h000001};
        vecs[6] = '{24'hA5C3E7, 8'd200, 24'h9981B5};
        for (int b = 0; b < 2; b++) for (int i = 0; i < N; i++) m_bank[b][i] = '0;
        m_front = 0;

        #1 resetn = 0;
        repeat (3) @(negedge clk);
        check("rst_avail", 24'(bitstream_available), 24'd0);
        check("rst_bitstream", bitstream, 24'd0);
        check("rst_swap_ack", 24'(swap_ack), 24'd0);
        check("rst_frame_done", 24'(frame_done), 24'd0);
        check("rst_avail5", 24'(bitstream_available2), 24'd0);
        resetn = 1;

        brightness = 8'd255;
        write_px(0, 24'h112233);
        write_px(1, 24'h445566);
        write_px(2, 24'h778899);
        write_px(3, 24'hAABBCC);
        swap_idle();
        run_frame("first");
        check("first_px0", fr_px[0], 24'h221133);
        for (int i = 1; i < N; i++) check("first_px", fr_px[i], grb(m_bank[m_front][i]));

        for (int v = 0; v < 7; v++) begin
            brightness = vecs[v].br;
            write_px(0, vecs[v].rgb);
            for (int i = 1; i < N; i++) write_px(2'(i), 24'h0);
            swap_idle();
            run_frame("vec");
            check("vec_px0", fr_px[0], vecs[v].exp);
            check("vec_px3", fr_px[3], 24'h0);
        end

        brightness = 8'd255;
        for (int i = 0; i < N; i++) write_px(2'(i), 24'h300000 + 24'(i * 24'h010101));
        @(negedge clk);
        enable = 1;
        for (int i = 0; i < N; i++) begin
            get_px(got, lat, ok);
            check("old_bank_px", got, grb(m_bank[m_front][i]));
            if (i == 1) repeat (2) begin
                @(negedge clk);
                swap_req = 1;
                @(negedge clk);
                swap_req = 0;
                check("no_ack_mid_frame", 24'(swap_ack), 24'd0);
            end
        end
        check("mid_frame_done", 24'(frame_done), 24'd1);
        gap_n = 0;
        acks = 0;
        for (int k = 0; k < 1100 && !bitstream_available; k++) begin
            bitstream_read = (k % 5 == 0);
            @(negedge clk);
            bitstream_read = 0;
            gap_n++;
            acks += int'(swap_ack);
        end
        check("gap_reached_next_frame", 24'(bitstream_available), 24'd1);
        check("gap_len_ge_1000", 24'(gap_n - 1 >= GAP), 24'd1);
        check("merged_single_ack", 24'(acks), 24'd1);
        enable = 0;
        m_front = !m_front;
        for (int i = 0; i < N; i++) begin
            get_px(got, lat, ok);
            check("new_bank_px", got, grb(m_bank[m_front][i]));
        end
        check("new_frame_done", 24'(frame_done), 24'd1);
        repeat (GAP + 5) @(negedge clk);

        @(negedge clk);
        wr_en = 1; wr_addr = 0; wr_data = 24'h5A6B7C; swap_req = 1;
        @(negedge clk);
        wr_en = 0; swap_req = 0;
        check("wr_swap_ack", 24'(swap_ack), 24'd1);
        m_bank[!m_front][0] = 24'h5A6B7C;
        m_front = !m_front;
        brightness = 8'd255;
        run_frame("wr_swap");
        check("wr_swap_px0", fr_px[0], 24'h6B5A7C);
        for (int i = 1; i < N; i++) check("wr_swap_px", fr_px[i], grb(m_bank[m_front][i]));

        brightness = 8'd255;
        @(negedge clk);
        enable = 1;
        lat = 0;
        while (!bitstream_available && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check("pre_rst_avail", 24'(bitstream_available), 24'd1);
        #2 resetn = 0;
        #1;
        check("async_rst_avail", 24'(bitstream_available), 24'd0);
        check("async_rst_bitstream", bitstream, 24'd0);
        enable = 0;
        repeat (3) begin
            @(negedge clk);
            check("rst_no_frame_done", 24'(frame_done), 24'd0);
        end
        resetn = 1;
        m_front = 0;
        brightness = 8'd255;
        run_frame("post_rst");
        for (int i = 0; i < N; i++) check("post_rst_px", fr_px[i], grb(m_bank[0][i]));

        brightness = 8'd255;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            wr_en2 = 1;
            wr_addr2 = 3'(i);
            wr_data = (i < 5) ? 24'h102030 + 24'(i * 24'h111111) : 24'hDEAD00;
        end
        @(negedge clk);
        wr_en2 = 0;
        @(negedge clk);
        swap_req = 1;
        @(negedge clk);
        swap_req = 0;
        check("swap_ack5", 24'(swap_ack2), 24'd1);
        m_front = !m_front;
        @(negedge clk);
        enable2 = 1;
        @(negedge clk);
        enable2 = 0;
        for (int i = 0; i < 5; i++) begin
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!bitstream_available2 && lat < 8);
            check("oor_px", bitstream2, grb(24'h102030 + 24'(i * 24'h111111)));
            check("oor_no_x", 24'($isunknown({bitstream2, bitstream_available2})), 24'd0);
            bitstream_read = 1;
            @(negedge clk);
            bitstream_read = 0;
            check("oor_frame_done", 24'(frame_done2), 24'(i == 4));
            check("idle_ignores_read", 24'(frame_done | bitstream_available), 24'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
